// File: rtl/bp_pkg.sv
// Shared types and the 2-bit saturating counter step for the branch predictor.
package bp_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT = 2'b00;
  localparam bp_ctr_t BP_WNT = 2'b01;
  localparam bp_ctr_t BP_WT  = 2'b10;
  localparam bp_ctr_t BP_ST  = 2'b11;

  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != BP_ST) nxt = bp_ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != BP_SNT) nxt = bp_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB: combinational fetch read, registered write, async-reset valid bits.
// 0-cycle read, 1-cycle write visibility; never stalls, writes accepted every cycle.
module branch_target_buffer #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_hit,
  output logic [XLEN-1:0]       rd_target,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [XLEN-1:0]       wr_target,
  output logic                  wr_match
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic [DEPTH-1:0]    valid_mem;
  logic [TAG_BITS-1:0] tag_mem    [DEPTH];
  logic [XLEN-1:0]     target_mem [DEPTH];

  assign rd_hit    = valid_mem[rd_idx] & (tag_mem[rd_idx] == rd_tag);
  assign rd_target = target_mem[rd_idx];
  // Whether the write slot already belongs to wr_tag; the counter logic needs this on every update.
  assign wr_match  = valid_mem[wr_idx] & (tag_mem[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem <= '0;
    end else if (wr_en) begin
      valid_mem[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: 2-bit counters plus tagged BTB, retrained from Execute resolution.
// Lookup 0 cycles, update visible 1 cycle later; stall_e_i holds off all updates.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] pc_f_i,
  output logic            pc_src_pred_f_o,
  output logic [XLEN-1:0] pred_target_f_o,
  input  logic [XLEN-1:0] pc_e_i,
  input  logic            branch_e_i,
  input  logic            stall_e_i,
  input  logic            pc_src_res_e_i,
  input  logic [XLEN-1:0] pc_target_e_i,
  input  logic            pc_src_pred_e_i,
  input  logic            target_match_e_i,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic [INDEX_BITS-1:0] idx_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0]   tag_f;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  hit_f;
  logic                  match_e;
  logic                  upd;
  logic                  mispredict;
  bp_ctr_t               ctr_mem [DEPTH];
  bp_ctr_t               ctr_base;
  bp_ctr_t               ctr_new;
  logic                  unused_pc_bits;

  assign idx_f = pc_f_i[INDEX_BITS+1:2];
  assign tag_f = pc_f_i[XLEN-1:INDEX_BITS+2];
  assign idx_e = pc_e_i[INDEX_BITS+1:2];
  assign tag_e = pc_e_i[XLEN-1:INDEX_BITS+2];
  assign unused_pc_bits = ^{pc_f_i[1:0], pc_e_i[1:0]};

  assign upd = branch_e_i & ~stall_e_i;

  branch_target_buffer #(
    .XLEN       (XLEN),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_btb (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .rd_idx    (idx_f),
    .rd_tag    (tag_f),
    .rd_hit    (hit_f),
    .rd_target (pred_target_f_o),
    .wr_en     (upd & pc_src_res_e_i),
    .wr_idx    (idx_e),
    .wr_tag    (tag_e),
    .wr_target (pc_target_e_i),
    .wr_match  (match_e)
  );

  assign pc_src_pred_f_o = hit_f & ctr_mem[idx_f][1];

  // A counter owned by another branch (or an empty slot) restarts from weakly-not-taken.
  assign ctr_base = match_e ? ctr_mem[idx_e] : BP_WNT;
  assign ctr_new  = bp_ctr_next(ctr_base, pc_src_res_e_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) ctr_mem[i] <= BP_WNT;
    end else if (upd) begin
      ctr_mem[idx_e] <= ctr_new;
    end
  end

  assign mispredict = upd & ((pc_src_pred_e_i != pc_src_res_e_i) |
                             (pc_src_res_e_i & pc_src_pred_e_i & ~target_match_e_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mispredict_cnt_o <= '0;
    end else if (mispredict) begin
      mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue scoreboard of expected observations.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] pc_f_i;
  logic        pc_src_pred_f_o;
  logic [31:0] pred_target_f_o;
  logic [31:0] pc_e_i;
  logic        branch_e_i;
  logic        stall_e_i;
  logic        pc_src_res_e_i;
  logic [31:0] pc_target_e_i;
  logic        pc_src_pred_e_i;
  logic        target_match_e_i;
  logic [31:0] mispredict_cnt_o;

  int          vectors = 0;
  int          fails   = 0;
  logic [31:0] exp_cnt = '0;
  string       name_q [$];
  logic [31:0] exp_q  [$];

  branch_predictor dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .pc_f_i           (pc_f_i),
    .pc_src_pred_f_o  (pc_src_pred_f_o),
    .pred_target_f_o  (pred_target_f_o),
    .pc_e_i           (pc_e_i),
    .branch_e_i       (branch_e_i),
    .stall_e_i        (stall_e_i),
    .pc_src_res_e_i   (pc_src_res_e_i),
    .pc_target_e_i    (pc_target_e_i),
    .pc_src_pred_e_i  (pc_src_pred_e_i),
    .target_match_e_i (target_match_e_i),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic exp_push(input string name, input logic [31:0] v);
    name_q.push_back(name);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       n;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      n = name_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", n, obs, e);
      end
    end
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic taken,
                      input logic chk_tgt, input logic [31:0] tgt);
    pc_f_i = pc;
    exp_push({name, "_pred"}, {31'd0, taken});
    if (chk_tgt) exp_push({name, "_tgt"}, tgt);
    #1;
    chk({31'd0, pc_src_pred_f_o});
    if (chk_tgt) chk(pred_target_f_o);
  endtask

  task automatic cnt_chk(input string name);
    exp_push(name, exp_cnt);
    #1;
    chk(mispredict_cnt_o);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic res,
                     input logic pred, input logic match);
    pc_e_i = pc; pc_target_e_i = tgt; pc_src_res_e_i = res;
    pc_src_pred_e_i = pred; target_match_e_i = match;
    branch_e_i = 1'b1; stall_e_i = 1'b0;
    if ((pred != res) || (res && pred && !match)) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk_i); #1;
    branch_e_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; pc_f_i = 32'h100; pc_e_i = '0; branch_e_i = 1'b0; stall_e_i = 1'b0;
    pc_src_res_e_i = 1'b0; pc_target_e_i = '0; pc_src_pred_e_i = 1'b0; target_match_e_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    cnt_chk("rst_cnt");
    look("rst", 32'h100, 1'b0, 1'b0, '0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    look("cold", 32'h100, 1'b0, 1'b0, '0);

    // WNT -> WT -> ST
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    look("taken1", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 32'h80, 1'b1, 1'b1, 1'b1);
    look("taken2", 32'h100, 1'b1, 1'b1, 32'h80);
    cnt_chk("cnt_train");

    // ST -> WT keeps the target, then down to SNT and saturate
    upd(32'h100, 32'h80, 1'b0, 1'b1, 1'b1);
    look("nt1", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 32'h80, 1'b0, 1'b1, 1'b1);
    look("nt2", 32'h100, 1'b0, 1'b0, '0);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 1'b1);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 1'b1);
    look("nt4", 32'h100, 1'b0, 1'b0, '0);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    look("sat_up1", 32'h100, 1'b0, 1'b0, '0);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    look("sat_up2", 32'h100, 1'b1, 1'b1, 32'h80);
    cnt_chk("cnt_sat");

    // Aliasing: 0x200 shares index 0 with 0x100
    upd(32'h100, 32'h80, 1'b1, 1'b1, 1'b1);
    look("alias_miss", 32'h200, 1'b0, 1'b0, '0);
    upd(32'h200, 32'h300, 1'b1, 1'b0, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, '0);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    upd(32'h200, 32'h300, 1'b0, 1'b1, 1'b1);
    look("alias_reinit", 32'h200, 1'b0, 1'b0, '0);

    // Same-cycle update and lookup: pre-update contents are returned
    pc_e_i = 32'h104; pc_target_e_i = 32'h44; pc_src_res_e_i = 1'b1;
    pc_src_pred_e_i = 1'b0; target_match_e_i = 1'b0; branch_e_i = 1'b1;
    exp_cnt = exp_cnt + 32'd1;
    look("same_cyc", 32'h104, 1'b0, 1'b0, '0);
    @(posedge clk_i); #1;
    branch_e_i = 1'b0;
    look("next_cyc", 32'h104, 1'b1, 1'b1, 32'h44);
    cnt_chk("cnt_same");

    // Asynchronous reset away from any clock edge
    #2;
    rst_n_i = 1'b0;
    exp_cnt = '0;
    cnt_chk("async_rst_cnt");
    look("async_rst", 32'h104, 1'b0, 1'b0, '0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Held branch updates once, when the stall drops
    pc_e_i = 32'h108; pc_target_e_i = 32'h200; pc_src_res_e_i = 1'b1;
    pc_src_pred_e_i = 1'b0; target_match_e_i = 1'b0; branch_e_i = 1'b1; stall_e_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      look("stall_pred", 32'h108, 1'b0, 1'b0, '0);
      cnt_chk("stall_cnt");
    end
    stall_e_i = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    @(posedge clk_i); #1;
    branch_e_i = 1'b0;
    look("unstall", 32'h108, 1'b1, 1'b1, 32'h200);
    cnt_chk("cnt_after_stall");
    upd(32'h108, 32'h200, 1'b0, 1'b0, 1'b1);
    look("once_only", 32'h108, 1'b0, 1'b0, '0);

    // Correct direction, wrong target counts; right target does not
    upd(32'h10C, 32'h400, 1'b1, 1'b1, 1'b0);
    cnt_chk("cnt_tgt_miss");
    upd(32'h10C, 32'h400, 1'b1, 1'b1, 1'b1);
    cnt_chk("cnt_tgt_hit");

    if (name_q.size() != 0) begin
      vectors++;
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", name_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
